// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning HI/LO.
// Shift-add multiply and restoring divide, one bit per cycle.
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] acc;

  logic               neg_a;
  logic               neg_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_r;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign neg_a = ~md_op[0] & a[WIDTH-1];
  assign neg_b = ~md_op[0] & b[WIDTH-1];

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, ma} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    div_r    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_r - {1'b0, mb};
    if (!div_diff[WIDTH])
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_next = {div_r[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Divide by zero falls out of the datapath: remainder
  // is |a|, re-signed back to a; only the quotient is forced.
  always_comb begin
    prod = acc;
    if (sa ^ sb) prod = '0 - acc;
    quo = acc[WIDTH-1:0];
    if (sa ^ sb) quo = '0 - acc[WIDTH-1:0];
    if (mb == '0) quo = '1;
    rem = acc[2*WIDTH-1:WIDTH];
    if (sa) rem = '0 - acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      op    <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      ma    <= '0;
      mb    <= '0;
      acc   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op    <= md_op;
            sa    <= neg_a;
            sb    <= neg_b;
            ma    <= neg_a ? '0 - a : a;
            mb    <= neg_b ? '0 - b : b;
            state <= S_LOAD;
          end else begin
            if (hi_we) hi <= wd;
            if (lo_we) lo <= wd;
          end
        end
        S_LOAD: begin
          acc   <= op[1] ? {{WIDTH{1'b0}}, ma}
                         : {{WIDTH{1'b0}}, mb};
          cnt   <= '0;
          busy  <= 1'b1;
          state <= S_RUN;
        end
        S_RUN: begin
          acc <= op[1] ? div_next : mul_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == '1) state <= S_FIX;
        end
        S_FIX: begin
          if (op[1]) begin
            hi <= rem;
            lo <= quo;
          end else begin
            {hi, lo} <= prod;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit with a reference
// model built on plain SV arithmetic.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  md_op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wd = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .md_op(md_op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_md(
    input logic [1:0] op,
    input logic [31:0] x,
    input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    int              sq;
    int              sr;
    logic [31:0]     uq;
    logic [31:0]     ur;
    case (op)
      2'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return sp;
      end
      2'd1: begin
        up = longint'({32'd0, x}) * longint'({32'd0, y});
        return up;
      end
      2'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return {32'd0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        uq = x / y;
        ur = x % y;
        return {ur, uq};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest
  // outstanding request, 34 edges after its start edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      done_cnt++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected 0");
      end else begin
        e = q.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("latency", cyc - e.n, 34);
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic wh,
                        input logic wl,
                        input logic [31:0] wv);
    logic [63:0] r;
    exp_t        e;
    int          bad;
    int          t;
    r = ref_md(op, x, y);
    @(negedge clk);
    start = 1'b1; md_op = op; a = x; b = y;
    hi_we = wh; lo_we = wl; wd = wv;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom; md_op = 2'($urandom);
    wd = $urandom;
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.n  = cyc;
    q.push_back(e);
    @(negedge clk);
    check("hold_at_start", {hi, lo}, {m_hi, m_lo});
    m_hi = e.hi;
    m_lo = e.lo;
    bad = 0;
    repeat (33) begin
      @(negedge clk);
      if (busy !== 1'b1) bad++;
    end
    check("busy_window", bad, 0);
    t = 0;
    while (q.size() != 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("result_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic write_hilo(input logic wh,
                            input logic wl,
                            input logic [31:0] wv);
    @(negedge clk);
    hi_we = wh; lo_we = wl; wd = wv;
    @(posedge clk);
    #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (wh) m_hi = wv;
    if (wl) m_lo = wv;
    @(negedge clk);
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  initial begin
    int          d0;
    int          t;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst_n = 1'b1;

    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 0, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op(2'd3, 32'd7, 32'd2, 0, 0, 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'd3, 32'd100, 32'd0, 0, 0, 0);
    run_op(2'd2, 32'hFFFF_FF9C, 32'd0, 0, 0, 0);

    // Contention: second start and MTHI mid-flight.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; md_op = 2'd1; a = 32'd5; b = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    q.push_back('{hi: 32'd0, lo: 32'd30, n: cyc});
    m_hi = 32'd0;
    m_lo = 32'd30;
    repeat (10) @(negedge clk);
    start = 1'b1; md_op = 2'd3; a = 32'd9; b = 32'd3;
    hi_we = 1'b1; wd = 32'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("contend_timeout", q.size(), 0);
    q.delete();
    repeat (40) @(negedge clk);
    check("contend_done_count", done_cnt - d0, 1);
    check("contend_hi", hi, 0);

    write_hilo(1, 0, 32'h1234);
    write_hilo(1, 1, 32'h0ABC);
    write_hilo(0, 1, 32'h5A5A_0001);

    // Start wins over a same-cycle MTHI/MTLO.
    run_op(2'd1, 32'd2, 32'd3, 1, 1, 32'h5555);

    // Reset in the middle of MULT 3*3.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; md_op = 2'd0; a = 32'd3; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    m_hi = '0;
    m_lo = '0;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_op(2'd0, 32'd3, 32'd3, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op(rop, ra, rb, 1'($urandom), 1'($urandom),
             $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
